adder_result_checker: RTL

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

---
 rtl/adder_result_checker.sv | 95 +++++++++
 1 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: checks a stream of adder results against data_1 + data_2 + cin
// and keeps pass/fail counts and the first mismatching vector of each run.
module adder_result_checker #(
    parameter int WIDTH       = 16,
    parameter int NUM_VECTORS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic             cin,
    input  logic [WIDTH:0]   res,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH:0]   first_fail_exp,
    output logic [WIDTH:0]   first_fail_got
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

    state_t         r_state;
    logic [15:0]    r_acc_cnt, r_cmp_idx;
    logic           r_cmp_vld, r_ff_seen;
    logic [WIDTH:0] r_cmp_exp, r_cmp_got;
    logic           w_accept, w_start, w_match;

    assign in_ready = r_state == RUN && r_acc_cnt <= LAST;
    assign w_accept = in_valid && in_ready;
    assign w_start  = start && (r_state == IDLE || r_state == DONE);
    assign w_match  = r_cmp_exp == r_cmp_got;
    assign busy     = r_state == RUN || r_state == DRAIN;
    assign done     = r_state == DONE;
    assign all_pass = r_state == DONE && fail_count == 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_acc_cnt      <= '0;
            r_cmp_vld      <= 1'b0;
            r_cmp_idx      <= '0;
            r_cmp_exp      <= '0;
            r_cmp_got      <= '0;
            r_ff_seen      <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else begin
            r_cmp_vld <= w_accept;
            if (w_accept) begin
                r_cmp_idx <= r_acc_cnt;
                r_cmp_exp <= {1'b0, data_1} + {1'b0, data_2} + {{WIDTH{1'b0}}, cin};
                r_cmp_got <= res;
                r_acc_cnt <= r_acc_cnt + 16'd1;
            end
            if (r_cmp_vld) begin
                if (w_match) begin
                    pass_count <= pass_count + 16'(pass_count != 16'hFFFF);
                end else begin
                    fail_count <= fail_count + 16'(fail_count != 16'hFFFF);
                    if (!r_ff_seen) begin
                        r_ff_seen      <= 1'b1;
                        first_fail_idx <= r_cmp_idx;
                        first_fail_exp <= r_cmp_exp;
                        first_fail_got <= r_cmp_got;
                    end
                end
            end
            // A new run wipes every result of the previous one on the same edge
            if (w_start) begin
                r_acc_cnt      <= '0;
                r_cmp_vld      <= 1'b0;
                r_ff_seen      <= 1'b0;
                pass_count     <= '0;
                fail_count     <= '0;
                first_fail_idx <= '0;
                first_fail_exp <= '0;
                first_fail_got <= '0;
            end
            case (r_state)
                IDLE, DONE: r_state <= start ? RUN : r_state;
                RUN:        r_state <= (w_accept && r_acc_cnt == LAST) ? DRAIN : RUN;
                default:    r_state <= DONE;
            endcase
        end
    end
endmodule
